hdr_tonemap: RTL and testbench

HDR_TONEMAP -- requirements
Module: hdr_tonemap

---
 rtl/hdr_tonemap.sv | 181 ++++++++++++++++++
 tb/tb_hdr_tonemap.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/hdr_tonemap.sv
// Tone mapper: per-frame min/max statistics, a multi-cycle divide for per-channel
// scale, and a two-stage pipeline that maps log irradiance to RGB565.
module hdr_tonemap #(
   parameter int N      = 16,
   parameter int FP     = 8,
   parameter int PIXELS = 76800
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] lE_red,
   input  logic [N-1:0] lE_green,
   input  logic [N-1:0] lE_blue,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [15:0]  pix_out,
   output logic         out_valid,
   output logic         frame_done
);

   localparam int DW = N + FP;
   localparam int PW = 2 * N + 1;
   localparam int CW = $clog2(PIXELS + 1);
   localparam int TW = $clog2(DW + 1);

   typedef enum logic {STREAM = 1'b0, CALC = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [TW-1:0] calc_cnt_q, calc_cnt_d;
   logic          accept, last_accept, calc_setup, calc_iter, calc_last;
   logic          v1_q, out_valid_q, frame_done_q;
   logic [15:0]   pix_q, pix_d;
   logic [5:0]    code_w [3];

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      calc_cnt_d  = calc_cnt_q;
      in_ready    = 1'b0;
      accept      = 1'b0;
      last_accept = 1'b0;
      calc_setup  = 1'b0;
      calc_iter   = 1'b0;
      calc_last   = 1'b0;
      case (state_q)
         STREAM: begin
            in_ready = 1'b1;
            accept   = in_valid;
            if (in_valid) begin
               if (count_q == CW'(PIXELS - 1)) begin
                  last_accept = 1'b1;
                  count_d     = '0;
                  calc_cnt_d  = '0;
                  state_d     = CALC;
               end else begin
                  count_d = count_q + CW'(1);
               end
            end
         end
         CALC: begin
            calc_setup = (calc_cnt_q == '0);
            calc_iter  = !calc_setup;
            calc_cnt_d = calc_cnt_q + TW'(1);
            // Count 0 is setup, counts 1..DW each retire one quotient bit.
            if (calc_cnt_q == TW'(DW)) begin
               calc_last = 1'b1;
               state_d   = STREAM;
            end
         end
         default: state_d = STREAM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= STREAM;
         count_q      <= '0;
         calc_cnt_q   <= '0;
         v1_q         <= 1'b0;
         out_valid_q  <= 1'b0;
         pix_q        <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         calc_cnt_q   <= calc_cnt_d;
         v1_q         <= accept;
         out_valid_q  <= v1_q;
         frame_done_q <= calc_last;
         if (v1_q) pix_q <= pix_d;
      end
   end

   // 5-bit channels never exceed 31, so the fields cannot overlap.
   assign pix_d      = (16'(code_w[0]) << 11) | (16'(code_w[1]) << 5) | 16'(code_w[2]);
   assign pix_out    = pix_q;
   assign out_valid  = out_valid_q;
   assign frame_done = frame_done_q;

   for (genvar gi = 0; gi < 3; gi++) begin : g_ch
      localparam int M = (gi == 1) ? 63 : 31;
      localparam logic signed [N-1:0] MIN_INIT = {1'b0, {(N-1){1'b1}}};
      localparam logic signed [N-1:0] MAX_INIT = {1'b1, {(N-1){1'b0}}};

      logic signed [N-1:0] le_w, nmin_w, nmax_w;
      logic signed [N-1:0] run_min_q, run_max_q, shd_min_q, shd_max_q, act_min_q;
      logic [N-1:0]        act_scale_q, d1_q, sc1_q, scale_w;
      logic signed [N:0]   range_w, diff_w;
      logic [N:0]          dsr_q, rem_q, rem_nx;
      logic [N+1:0]        rem_sh;
      logic [DW-1:0]       dvd_q, quo_nx;
      logic [DW-2:0]       quo_q;
      logic                zero_q, q_bit;
      logic [PW-1:0]       prod_w, sh_w;

      assign le_w    = (gi == 0) ? lE_red : (gi == 1) ? lE_green : lE_blue;
      assign nmin_w  = (le_w < run_min_q) ? le_w : run_min_q;
      assign nmax_w  = (le_w > run_max_q) ? le_w : run_max_q;
      assign range_w = {shd_max_q[N-1], shd_max_q} - {shd_min_q[N-1], shd_min_q};

      // One restoring-division step; the remainder always stays below the divisor.
      assign rem_sh  = {rem_q, dvd_q[DW-1]};
      assign q_bit   = (rem_sh >= {1'b0, dsr_q});
      assign rem_nx  = q_bit ? (rem_sh[N:0] - dsr_q) : rem_sh[N:0];
      assign quo_nx  = {quo_q, q_bit};
      assign scale_w = (|quo_nx[DW-1:N]) ? '1 : quo_nx[N-1:0];

      assign diff_w      = {le_w[N-1], le_w} - {act_min_q[N-1], act_min_q};
      assign prod_w      = PW'(d1_q) * PW'(sc1_q);
      assign sh_w        = prod_w >> (2 * FP);
      assign code_w[gi]  = (sh_w > PW'(M)) ? 6'(M) : sh_w[5:0];

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            run_min_q   <= MIN_INIT;
            run_max_q   <= MAX_INIT;
            shd_min_q   <= '0;
            shd_max_q   <= '0;
            act_min_q   <= '0;
            act_scale_q <= N'(M) << FP;
            dsr_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            quo_q       <= '0;
            zero_q      <= 1'b0;
            d1_q        <= '0;
            sc1_q       <= '0;
         end else begin
            if (accept) begin
               d1_q  <= diff_w[N] ? '0 : diff_w[N-1:0];
               sc1_q <= act_scale_q;
               if (last_accept) begin
                  shd_min_q <= nmin_w;
                  shd_max_q <= nmax_w;
                  run_min_q <= MIN_INIT;
                  run_max_q <= MAX_INIT;
               end else begin
                  run_min_q <= nmin_w;
                  run_max_q <= nmax_w;
               end
            end
            if (calc_setup) begin
               dsr_q  <= range_w;
               rem_q  <= '0;
               quo_q  <= '0;
               dvd_q  <= DW'(M) << (2 * FP);
               zero_q <= (range_w == '0);
            end else if (calc_iter && !zero_q) begin
               rem_q <= rem_nx;
               quo_q <= quo_nx[DW-2:0];
               dvd_q <= dvd_q << 1;
            end
            if (calc_last) begin
               act_min_q   <= shd_min_q;
               act_scale_q <= zero_q ? '0 : scale_w;
            end
         end
      end
   end

endmodule

// File: tb/tb_hdr_tonemap.sv
// Directed bench for hdr_tonemap with a 4-pixel frame: reset, mapping,
// frame commit timing, flat frame, clamping and reset during the divide.
module tb_hdr_tonemap;
   localparam int N = 16;
   localparam int FP = 8;
   localparam int PIXELS = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  lE_red, lE_green, lE_blue;
   logic          in_valid;
   logic          in_ready;
   logic [15:0]   pix_out;
   logic          out_valid;
   logic          frame_done;
   int            checks = 0;
   int            failures = 0;

   always #5 clk = ~clk;

   hdr_tonemap #(.N(N), .FP(FP), .PIXELS(PIXELS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .lE_red     (lE_red),
      .lE_green   (lE_green),
      .lE_blue    (lE_blue),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .pix_out    (pix_out),
      .out_valid  (out_valid),
      .frame_done (frame_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [15:0] v);
      lE_red   = v;
      lE_green = v;
      lE_blue  = v;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic xfer(input logic [15:0] v, input logic [15:0] exp, input string tag);
      send(v);
      @(negedge clk);
      chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_pix"}, 32'(pix_out), 32'(exp));
      $display("xfer %s: lE=0x%04h pix_out=0x%04h", tag, v, pix_out);
   endtask

   task automatic last_px(input logic [15:0] v, input logic [15:0] exp, input string tag);
      int   busy = 0;
      logic fd_seen = 1'b0;
      send(v);
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (k == 2) begin
            chk({tag, "_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_pix"}, 32'(pix_out), 32'(exp));
         end
         if (in_ready) break;
         busy++;
         if (frame_done) fd_seen = 1'b1;
      end
      chk({tag, "_busy"}, 32'(busy), 32'd25);
      chk({tag, "_fd_early"}, 32'(fd_seen), 32'd0);
      chk({tag, "_fd"}, 32'(frame_done), 32'd1);
      @(negedge clk);
      chk({tag, "_fd_pulse"}, 32'(frame_done), 32'd0);
      $display("frame %s: lE=0x%04h busy=%0d", tag, v, busy);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      lE_red   = '0;
      lE_green = '0;
      lE_blue  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_pix", 32'(pix_out), 32'h0000);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_fd", 32'(frame_done), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;

      xfer(16'h0080, 16'h7BEF, "pre_frame");

      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Frame 1 under reset statistics: min 0, max 0x200.
      xfer(16'h0000, 16'h0000, "f1_p0");
      xfer(16'h0100, 16'hFFFF, "f1_p1");
      xfer(16'h0200, 16'hFFFF, "f1_p2");
      last_px(16'h0080, 16'h7BEF, "f1_p3");

      // Frame 2 under frame-1 scales (3968 / 8064): min -0x100, max 0x400.
      xfer(16'h0200, 16'hFFFF, "post_hi");
      xfer(16'h0100, 16'h7BEF, "post_mid");
      xfer(16'hFF00, 16'h0000, "clamp_lo");
      last_px(16'h0400, 16'hFFFF, "clamp_hi");

      // Range 1280: scales 1587 / 3225, d=1024 -> r=b=24, g=50.
      xfer(16'h0300, 16'hC658, "flat_p0");
      xfer(16'h0300, 16'hC658, "flat_p1");
      xfer(16'h0300, 16'hC658, "flat_p2");
      last_px(16'h0300, 16'hC658, "flat_p3");

      xfer(16'h0300, 16'h0000, "flat_map");
      xfer(16'h7F00, 16'h0000, "flat_big");
      xfer(16'h0200, 16'h0000, "flat_mid");
      send(16'h0000);

      repeat (11) @(negedge clk);
      chk("mid_calc_busy", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_ready", 32'(in_ready), 32'd1);
      chk("abort_valid", 32'(out_valid), 32'd0);
      chk("abort_pix", 32'(pix_out), 32'h0000);
      bad = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (frame_done || !in_ready) bad++;
      end
      chk("abort_no_fd", 32'(bad), 32'd0);
      $display("abort: reset during divide, stray cycles=%0d", bad);
      xfer(16'h0080, 16'h7BEF, "post_abort");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
